// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store.
// One command is in flight at a time. Data requests normally win arbitration.
// A streak counter forces a fetch grant after MAX_STREAK data grants made while fetch waited.
// A timeout aborts a command that the memory never answers.
// Every output is a register.

module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_STREAK = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst,

    // Instruction-fetch requester
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,

    // Load/store requester
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,

    output logic              err,

    // Memory port
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    // The timeout counter only has to reach TIMEOUT-2.
    localparam int unsigned TCW = $clog2(TIMEOUT);
    localparam int unsigned SCW = $clog2(MAX_STREAK + 1);

    // A command aborts at the edge that ends its (TIMEOUT-1)-th unanswered cycle.
    localparam logic [TCW-1:0] TC_LAST    = TCW'(TIMEOUT - 2);
    localparam logic [SCW-1:0] STREAK_MAX = SCW'(MAX_STREAK);

    typedef enum logic [1:0] {
        StIdle,
        StServeI,
        StServeD
    } state_e;

    state_e state_q, state_d;

    logic [TCW-1:0] tcnt_q, tcnt_d;
    logic [SCW-1:0] streak_q, streak_d;

    logic              i_gnt_q, i_gnt_d;
    logic              i_done_q, i_done_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic              d_gnt_q, d_gnt_d;
    logic              d_done_q, d_done_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              err_q, err_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic busy;
    logic done_ok;
    logic done_to;
    logic finish;
    logic can_arb;
    logic fetch_due;
    logic grant_i;
    logic grant_d;

    // Completion, timeout and arbitration decisions for the coming edge.
    always_comb begin
        busy      = (state_q != StIdle);
        done_ok   = busy & mem_ready;
        done_to   = busy & ~mem_ready & (tcnt_q == TC_LAST);
        finish    = done_ok | done_to;
        // A finishing command frees the port at the same edge, so there is no bubble.
        can_arb   = ~busy | finish;
        fetch_due = i_req & (streak_q == STREAK_MAX);
        grant_d   = can_arb & d_req & ~fetch_due;
        grant_i   = can_arb & i_req & ~grant_d;
    end

    // Next FSM state.
    always_comb begin
        state_d = state_q;
        if (grant_d) begin
            state_d = StServeD;
        end else if (grant_i) begin
            state_d = StServeI;
        end else if (can_arb) begin
            state_d = StIdle;
        end
    end

    // Timeout counter: restarts on a grant and counts unanswered serve cycles.
    always_comb begin
        tcnt_d = tcnt_q;
        if (grant_d || grant_i || !busy || finish) begin
            tcnt_d = '0;
        end else begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    // Streak counter: data grants made while fetch is waiting, saturating.
    always_comb begin
        streak_d = streak_q;
        if (!i_req || grant_i) begin
            streak_d = '0;
        end else if (grant_d && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    // Registered outputs: pulses default low, data and command fields hold.
    always_comb begin
        i_gnt_d     = grant_i;
        d_gnt_d     = grant_d;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        err_d       = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (finish) begin
            err_d     = done_to;
            mem_req_d = 1'b0;
            if (state_q == StServeI) begin
                i_done_d  = 1'b1;
                i_rdata_d = done_ok ? mem_rdata : '0;
            end else begin
                d_done_d = 1'b1;
                // Stores leave the load data register untouched.
                if (!mem_we_q) begin
                    d_rdata_d = done_ok ? mem_rdata : '0;
                end
            end
        end

        if (grant_d) begin
            mem_req_d   = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
        end else if (grant_i) begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = i_addr;
            mem_wdata_d = '0;
        end
    end

    // State, counters and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            tcnt_q      <= '0;
            streak_q    <= '0;
            i_gnt_q     <= 1'b0;
            i_done_q    <= 1'b0;
            i_rdata_q   <= '0;
            d_gnt_q     <= 1'b0;
            d_done_q    <= 1'b0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            streak_q    <= streak_d;
            i_gnt_q     <= i_gnt_d;
            i_done_q    <= i_done_d;
            i_rdata_q   <= i_rdata_d;
            d_gnt_q     <= d_gnt_d;
            d_done_q    <= d_done_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign i_gnt     = i_gnt_q;
    assign i_done    = i_done_q;
    assign i_rdata   = i_rdata_q;
    assign d_gnt     = d_gnt_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table, hand-written corner sequences and a
// randomized run checked against a transaction-level reference model.

module tb_mem_port_arbiter;

    localparam int unsigned MAXS = 4;
    localparam int unsigned TOUT = 8;
    localparam logic [31:0] DB   = 32'hDEADBEEF;
    localparam logic [31:0] A5   = 32'hA5A5A5A5;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    mem_port_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MAX_STREAK(MAXS),
        .TIMEOUT   (TOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_done   (i_done),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .err      (err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mreq, ig, dg, id, dd, er;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata, ir, dr;
    } exp_t;

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq, dwe;
        logic [31:0] daddr, dwdata;
        logic        rdy;
        logic [31:0] rdata;
        exp_t        e;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model: one outstanding transaction described as plain fields.
    bit          m_busy;
    bit          m_fetch;
    bit          m_we;
    logic [31:0] m_addr, m_wdata;
    int          m_served;
    int          m_streak;
    exp_t        ex;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
        end
    endtask

    task automatic check_outs(input exp_t e, input string t);
        chk({t, ".mem_req"}, 32'(mem_req), 32'(e.mreq));
        chk({t, ".i_gnt"},   32'(i_gnt),   32'(e.ig));
        chk({t, ".d_gnt"},   32'(d_gnt),   32'(e.dg));
        chk({t, ".i_done"},  32'(i_done),  32'(e.id));
        chk({t, ".d_done"},  32'(d_done),  32'(e.dd));
        chk({t, ".err"},     32'(err),     32'(e.er));
        chk({t, ".i_rdata"}, i_rdata,      e.ir);
        chk({t, ".d_rdata"}, d_rdata,      e.dr);
        if (e.mreq) begin
            chk({t, ".mem_addr"},  mem_addr,      e.addr);
            chk({t, ".mem_we"},    32'(mem_we),   32'(e.we));
            chk({t, ".mem_wdata"}, mem_wdata,     e.wdata);
        end
    endtask

    task automatic push(input logic [31:0] ir, ia, dr, dw, da, dd, rdy, rd,
                        input logic [31:0] emr, eig, edg, eid, edd, eer, ea, ewe, ewd, eir, edr);
        vec_t v;
        v.ireq = ir[0]; v.iaddr = ia; v.dreq = dr[0]; v.dwe = dw[0];
        v.daddr = da; v.dwdata = dd; v.rdy = rdy[0]; v.rdata = rd;
        v.e.mreq = emr[0]; v.e.ig = eig[0]; v.e.dg = edg[0];
        v.e.id = eid[0]; v.e.dd = edd[0]; v.e.er = eer[0];
        v.e.addr = ea; v.e.we = ewe[0]; v.e.wdata = ewd; v.e.ir = eir; v.e.dr = edr;
        vecs.push_back(v);
    endtask

    task automatic model_reset();
        m_busy = 0; m_fetch = 0; m_we = 0; m_addr = '0; m_wdata = '0;
        m_served = 0; m_streak = 0;
        ex = '{mreq: 0, ig: 0, dg: 0, id: 0, dd: 0, er: 0, addr: '0, we: 0,
               wdata: '0, ir: '0, dr: '0};
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        exp_t n = ex;
        bit   ok, to;
        n.ig = 0; n.dg = 0; n.id = 0; n.dd = 0; n.er = 0;
        ok = m_busy && mem_ready;
        to = m_busy && !mem_ready && (m_served + 1 >= int'(TOUT) - 1);
        if (ok || to) begin
            if (m_fetch) begin
                n.id = 1;
                n.ir = ok ? mem_rdata : 32'h0;
            end else begin
                n.dd = 1;
                if (!m_we) n.dr = ok ? mem_rdata : 32'h0;
            end
            n.er   = to;
            m_busy = 0;
        end else if (m_busy) begin
            m_served++;
        end
        if (!m_busy) begin
            if (d_req && !(i_req && m_streak == int'(MAXS))) begin
                m_busy = 1; m_fetch = 0; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
                m_served = 0; n.dg = 1;
                if (i_req && m_streak < int'(MAXS)) m_streak++;
            end else if (i_req) begin
                m_busy = 1; m_fetch = 1; m_we = 0; m_addr = i_addr; m_wdata = '0;
                m_served = 0; n.ig = 1; m_streak = 0;
            end
        end
        if (!i_req) m_streak = 0;
        n.mreq = m_busy; n.addr = m_addr; n.we = m_we; n.wdata = m_wdata;
        ex = n;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t zero;
        rst = 1'b1;
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        mem_ready = 0; mem_rdata = '0;
        model_reset();
        zero = ex;

        // Single fetch: ready on the fourth mem_req cycle, stray ready while idle.
        push(1, 'h40, 0, 0, 0, 0, 0, 0,            1, 1, 0, 0, 0, 0, 'h40, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++)
            push(0, 0, 0, 0, 0, 0, 0, 'h5A5A5A5A,  1, 0, 0, 0, 0, 0, 'h40, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0, 1, DB,              0, 0, 0, 1, 0, 0, 0, 0, 0, DB, 0);
        push(0, 0, 0, 0, 0, 0, 1, 'h12345678,      0, 0, 0, 0, 0, 0, 0, 0, 0, DB, 0);
        // Store with the requester changing its fields after the grant.
        push(0, 0, 1, 1, 'h8, 'h55, 0, 0,          1, 0, 1, 0, 0, 0, 'h8, 1, 'h55, DB, 0);
        push(0, 0, 0, 1, 'h1234, 'h99, 0, 0,       1, 0, 0, 0, 0, 0, 'h8, 1, 'h55, DB, 0);
        push(0, 0, 0, 0, 'hFFFF, 'h77, 1, 'hCAFE,  0, 0, 0, 0, 1, 0, 0, 0, 0, DB, 0);
        // Late ready on the timeout edge: normal completion.
        push(0, 0, 1, 0, 'h300, 0, 0, 0,           1, 0, 1, 0, 0, 0, 'h300, 0, 0, DB, 0);
        for (int k = 0; k < 6; k++)
            push(0, 0, 0, 0, 0, 0, 0, 'h1111,      1, 0, 0, 0, 0, 0, 'h300, 0, 0, DB, 0);
        push(0, 0, 0, 0, 0, 0, 1, A5,              0, 0, 0, 0, 1, 0, 0, 0, 0, DB, A5);
        // Timeout on a load with a fetch pending; fetch granted at the abort edge.
        push(0, 0, 1, 0, 'h100, 0, 0, 0,           1, 0, 1, 0, 0, 0, 'h100, 0, 0, DB, A5);
        for (int k = 0; k < 2; k++)
            push(0, 0, 0, 1, 0, 'hBAD, 0, 0,       1, 0, 0, 0, 0, 0, 'h100, 0, 0, DB, A5);
        for (int k = 0; k < 4; k++)
            push(1, 'h200, 0, 1, 0, 'hBAD, 0, 0,   1, 0, 0, 0, 0, 0, 'h100, 0, 0, DB, A5);
        push(1, 'h200, 0, 1, 0, 'hBAD, 0, 0,       1, 1, 0, 0, 1, 1, 'h200, 0, 0, DB, 0);
        push(0, 0, 0, 0, 0, 0, 1, 'h11,            0, 0, 0, 1, 0, 0, 0, 0, 0, 'h11, 0);

        #1;
        check_outs(zero, "reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            i_req = vecs[i].ireq; i_addr = vecs[i].iaddr;
            d_req = vecs[i].dreq; d_we = vecs[i].dwe;
            d_addr = vecs[i].daddr; d_wdata = vecs[i].dwdata;
            mem_ready = vecs[i].rdy; mem_rdata = vecs[i].rdata;
            @(posedge clk);
            @(negedge clk);
            check_outs(vecs[i].e, $sformatf("vec%0d", i));
        end

        // Starvation: both requesters always pending, memory ready every cycle.
        i_req = 1; i_addr = 32'h1000; d_req = 1; d_we = 0; d_addr = 32'h2000;
        mem_ready = 1; mem_rdata = 32'h77;
        for (int k = 0; k < 10; k++) begin
            logic [7:0] got, want;
            @(posedge clk);
            @(negedge clk);
            got  = (i_gnt && !d_gnt) ? "I" : (d_gnt && !i_gnt) ? "D" : "-";
            want = (k % 5 == 4) ? "I" : "D";
            chk($sformatf("starve.grant%0d", k), 32'(got), 32'(want));
            chk($sformatf("starve.mem_req%0d", k), 32'(mem_req), 32'h1);
        end
        i_req = 0; d_req = 0;
        @(posedge clk);
        @(negedge clk);
        chk("starve.drain", 32'(mem_req), 32'h0);
        mem_ready = 0;

        // Asynchronous reset while a load is outstanding.
        d_req = 1; d_we = 0; d_addr = 32'h100;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid.pre_mem_req", 32'(mem_req), 32'h1);
        chk("rstmid.pre_d_gnt", 32'(d_gnt), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid.mem_req", 32'(mem_req), 32'h0);
        chk("rstmid.d_gnt", 32'(d_gnt), 32'h0);
        chk("rstmid.d_done", 32'(d_done), 32'h0);
        chk("rstmid.mem_addr", mem_addr, 32'h0);
        chk("rstmid.i_rdata", i_rdata, 32'h0);
        d_req = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_outs(zero, $sformatf("rstidle%0d", k));
        end

        // Randomized run against the reference model.
        model_reset();
        begin
            int rdy_pct = 50;
            for (int c = 0; c < 3000; c++) begin
                if (c % 64 == 0) begin
                    case ($urandom_range(0, 2))
                        0:       rdy_pct = 90;
                        1:       rdy_pct = 40;
                        default: rdy_pct = 5;
                    endcase
                end
                i_req     = ($urandom_range(0, 99) < 60);
                d_req     = ($urandom_range(0, 99) < 70);
                d_we      = ($urandom_range(0, 1) == 1);
                i_addr    = $urandom();
                d_addr    = $urandom();
                d_wdata   = $urandom();
                mem_ready = ($urandom_range(0, 99) < rdy_pct);
                mem_rdata = $urandom();
                model_step();
                @(posedge clk);
                @(negedge clk);
                check_outs(ex, $sformatf("rnd%0d", c));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
